// File: rtl/ntt_coef_buffer_if.sv
// Load/unload stream bundle for ntt_coef_buffer.
// slave is the buffer side, master the producer/consumer side.
interface ntt_coef_buffer_if #(
  parameter int LOGQ = 60
);
  logic            s_valid;
  logic            s_ready;
  logic [LOGQ-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [LOGQ-1:0] m_data;
  logic            m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ntt_coef_buffer.sv
// Two-bank coefficient buffer between a stream and an NTT core.
// NTT_BUF_REDUCE_EN: subtract q once from load beats >= q.
module ntt_coef_buffer #(
  parameter  int LOGQ = 60,
  parameter  int LOGN = 12,
  localparam int AW   = (LOGN < 9) ? 10 : LOGN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_intt_i,
  input  logic [LOGQ-1:0] q_i,
  ntt_coef_buffer_if.slave io,
  output logic            ntt_start_o,
  output logic            ntt_intt_o,
  input  logic [AW-1:0]   ntt_read_address_i,
  input  logic [AW-1:0]   ntt_write_address_i,
  input  logic            ntt_wea_i,
  output logic [LOGQ-1:0] ntt_data_in_0_o,
  output logic [LOGQ-1:0] ntt_data_in_1_o,
  input  logic [LOGQ-1:0] ntt_data_out_0_i,
  input  logic [LOGQ-1:0] ntt_data_out_1_i,
  input  logic            ntt_finish_i,
  output logic            busy_o
);
  localparam int N  = 1 << LOGN;
  localparam int H  = N / 2;
  localparam int HW = LOGN - 1;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    UNLOAD
  } state_e;

  state_e          state_q, state_d;
  logic [LOGN-1:0] lc_q, lc_d;
  logic [LOGN-1:0] uc_q, uc_d;
  logic            done_q, done_d;
  logic            start_q, start_d;
  logic            intt_q, intt_d;
  logic            mv_q, mv_d;
  logic            ml_q, ml_d;
  logic [LOGQ-1:0] md_q, md_d;

  logic [LOGQ-1:0] bank0 [H];
  logic [LOGQ-1:0] bank1 [H];
  logic [LOGQ-1:0] din0_q, din1_q;
  logic [LOGQ-1:0] ld_data;
  logic [LOGQ-1:0] uc_word;
  logic            ld_we;
  logic [HW-1:0]   ra, wa;

`ifdef NTT_BUF_REDUCE_EN
  assign ld_data = (io.s_data >= q_i) ?
                   io.s_data - q_i : io.s_data;
`else
  logic unused_q;
  assign unused_q = ^q_i;
  assign ld_data  = io.s_data;
`endif

  logic unused_addr;
  assign unused_addr = ^{ntt_read_address_i[AW-1:HW],
                         ntt_write_address_i[AW-1:HW]};

  assign ra    = ntt_read_address_i[HW-1:0];
  assign wa    = ntt_write_address_i[HW-1:0];
  assign ld_we = (state_q == LOAD) && io.s_valid;

  // Unload prefetch: the word at uc_q feeds the output register
  assign uc_word = uc_q[HW] ? bank1[uc_q[HW-1:0]]
                            : bank0[uc_q[HW-1:0]];

  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    uc_d    = uc_q;
    done_d  = done_q;
    start_d = 1'b0;
    intt_d  = intt_q;
    mv_d    = mv_q;
    ml_d    = ml_q;
    md_d    = md_q;
    unique case (state_q)
      LOAD: begin
        if (io.s_valid) begin
          lc_d = lc_q + LOGN'(1);
          if (lc_q == '0) intt_d = cfg_intt_i;
          if (lc_q == LAST) state_d = RUN;
        end
      end
      RUN: begin
        start_d = 1'b1;
        if (start_q && ntt_finish_i) begin
          start_d = 1'b0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (mv_q && io.m_ready && ml_q) begin
          state_d = LOAD;
          mv_d    = 1'b0;
          ml_d    = 1'b0;
          uc_d    = '0;
          done_d  = 1'b0;
        end else if ((!mv_q || io.m_ready) && !done_q) begin
          mv_d   = 1'b1;
          md_d   = uc_word;
          ml_d   = (uc_q == LAST);
          uc_d   = uc_q + LOGN'(1);
          done_d = (uc_q == LAST);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      lc_q    <= '0;
      uc_q    <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      intt_q  <= 1'b0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      uc_q    <= uc_d;
      done_q  <= done_d;
      start_q <= start_d;
      intt_q  <= intt_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      md_q    <= md_d;
    end
  end

  // Reads sample the pre-edge contents, giving read-before-write
  always_ff @(posedge clk) begin
    if (rst) begin
      din0_q <= '0;
      din1_q <= '0;
    end else begin
      din0_q <= bank0[ra];
      din1_q <= bank1[ra];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ld_we) begin
      if (lc_q[HW]) bank1[lc_q[HW-1:0]] <= ld_data;
      else          bank0[lc_q[HW-1:0]] <= ld_data;
    end else if (!rst && state_q == RUN && ntt_wea_i) begin
      bank0[wa] <= ntt_data_out_0_i;
      bank1[wa] <= ntt_data_out_1_i;
    end
  end

  assign io.s_ready      = (state_q == LOAD);
  assign io.m_valid      = mv_q;
  assign io.m_data       = md_q;
  assign io.m_last       = ml_q;
  assign ntt_start_o     = start_q;
  assign ntt_intt_o      = intt_q;
  assign ntt_data_in_0_o = din0_q;
  assign ntt_data_in_1_o = din1_q;
  assign busy_o          = (state_q != LOAD) || (lc_q != '0);
endmodule

// File: tb/tb_ntt_coef_buffer.sv
// Self-checking bench for ntt_coef_buffer, LOGN=4, LOGQ=32.
// Random streams checked against a natural-order array model.
module tb_ntt_coef_buffer;
  localparam int LOGQ = 32;
  localparam int LOGN = 4;
  localparam int N    = 16;
  localparam int AW   = 10;
`ifdef NTT_BUF_REDUCE_EN
  localparam bit REDUCE = 1'b1;
  localparam logic [31:0] EXP20 = 32'd3;
`else
  localparam bit REDUCE = 1'b0;
  localparam logic [31:0] EXP20 = 32'd20;
`endif

  logic clk, rst, cfg_intt;
  logic [31:0] q;
  logic ntt_start, ntt_intt, wea, finish, busy;
  logic [AW-1:0] ra, wa;
  logic [31:0] din0, din1, dout0, dout1;

  ntt_coef_buffer_if #(.LOGQ(LOGQ)) bus ();

  ntt_coef_buffer #(.LOGQ(LOGQ), .LOGN(LOGN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_intt_i          (cfg_intt),
    .q_i                 (q),
    .io                  (bus),
    .ntt_start_o         (ntt_start),
    .ntt_intt_o          (ntt_intt),
    .ntt_read_address_i  (ra),
    .ntt_write_address_i (wa),
    .ntt_wea_i           (wea),
    .ntt_data_in_0_o     (din0),
    .ntt_data_in_1_o     (din1),
    .ntt_data_out_0_i    (dout0),
    .ntt_data_out_1_i    (dout1),
    .ntt_finish_i        (finish),
    .busy_o              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [N];
  logic [31:0] stim [N];
  logic cur_intt;

  function automatic logic [31:0] red(
    input logic [31:0] x, input logic [31:0] qq);
    return (REDUCE && x >= qq) ? x - qq : x;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; cfg_intt = 0; q = 32'hFFFF_FFFF;
    bus.s_valid = 0; bus.s_data = 0; bus.m_ready = 0;
    ra = 0; wa = 0; wea = 0; finish = 0;
    dout0 = 0; dout1 = 0;
    repeat (3) step();
    checks++;
    if (din0 !== 0 || din1 !== 0) begin
      errors++;
      $display("FAIL rst_din: got %h/%h want 0/0", din0, din1);
    end
    rst = 0;
    step();
    checks++;
    if (bus.s_ready !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL rst_ready: rdy %b busy %b want 1/0",
               bus.s_ready, busy);
    end
    checks++;
    if (bus.m_valid !== 0 || bus.m_last !== 0 || ntt_start !== 0) begin
      errors++;
      $display("FAIL rst_out: mv %b ml %b st %b want 0",
               bus.m_valid, bus.m_last, ntt_start);
    end
  endtask

  task automatic load_beats(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.s_valid = 0;
        wea = 1'($urandom); wa = AW'($urandom);
        finish = 1'($urandom);
        step();
      end
      bus.s_valid = 1;
      bus.s_data = stim[k];
      cfg_intt = (k == 0) ? cur_intt : ~cur_intt;
      wea = 1'($urandom); wa = AW'($urandom);
      dout0 = $urandom; dout1 = $urandom;
      finish = 1'($urandom);
      mdl[k] = red(stim[k], q);
      step();
    end
    bus.s_valid = 0; wea = 0; finish = 0;
    cfg_intt = ~cur_intt;
  endtask

  task automatic check_run_entry();
    checks++;
    if (bus.s_ready !== 0 || busy !== 1 || ntt_start !== 0) begin
      errors++;
      $display("FAIL run_entry: rdy %b busy %b st %b want 0/1/0",
               bus.s_ready, busy, ntt_start);
    end
    step();
    checks++;
    if (ntt_start !== 1 || ntt_intt !== cur_intt) begin
      errors++;
      $display("FAIL run_start: st %b intt %b want 1/%b",
               ntt_start, ntt_intt, cur_intt);
    end
  endtask

  task automatic load_full();
    load_beats(0, N);
    check_run_entry();
  endtask

  task automatic rd_check(input int a);
    ra = AW'(a);
    step();
    checks++;
    if (din0 !== mdl[a] || din1 !== mdl[a+8]) begin
      errors++;
      $display("FAIL rd_%0d: got %h/%h want %h/%h",
               a, din0, din1, mdl[a], mdl[a+8]);
    end
  endtask

  task automatic finish_core();
    finish = 1;
    step();
    finish = 0;
    checks++;
    if (ntt_start !== 0) begin
      errors++;
      $display("FAIL start_drop: got %b want 0", ntt_start);
    end
  endtask

  task automatic unload(input int mode);
    int idx, cyc, first, last_hs;
    logic stall, rdy;
    logic [31:0] pd;
    idx = 0; cyc = 0; first = -1; last_hs = 0;
    stall = 0; pd = 0;
    while (idx < N && cyc < 400) begin
      if (stall) begin
        checks++;
        if (bus.m_valid !== 1 || bus.m_data !== pd) begin
          errors++;
          $display("FAIL stall_hold: mv %b d %h want 1/%h",
                   bus.m_valid, bus.m_data, pd);
        end
      end
      if (bus.m_valid === 1 && first < 0) first = cyc;
      case (mode)
        0: rdy = 1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      bus.m_ready = rdy;
      wea = 1'($urandom); wa = AW'($urandom);
      dout0 = $urandom; dout1 = $urandom;
      if (bus.m_valid === 1 && rdy) begin
        checks++;
        if (bus.m_data !== mdl[idx] ||
            bus.m_last !== 1'(idx == N - 1)) begin
          errors++;
          $display("FAIL unload_%0d: d %h l %b want %h/%b",
                   idx, bus.m_data, bus.m_last, mdl[idx],
                   idx == N - 1);
        end
        idx++;
        last_hs = cyc;
      end
      stall = (bus.m_valid === 1) && !rdy;
      pd = bus.m_data;
      step();
      cyc++;
    end
    bus.m_ready = 0; wea = 0;
    checks++;
    if (idx != N) begin
      errors++;
      $display("FAIL unload_timeout: got %0d words want %0d", idx, N);
    end
    checks++;
    if (first < 0 || first > 2) begin
      errors++;
      $display("FAIL first_valid: cycle %0d want <=2", first);
    end
    if (mode == 0) begin
      checks++;
      if (last_hs - first != N - 1) begin
        errors++;
        $display("FAIL throughput: span %0d want %0d",
                 last_hs - first, N - 1);
      end
    end
    checks++;
    if (bus.m_valid !== 0 || busy !== 0 || bus.s_ready !== 1) begin
      errors++;
      $display("FAIL unload_exit: mv %b busy %b rdy %b want 0/0/1",
               bus.m_valid, busy, bus.s_ready);
    end
  endtask

  task automatic test_load_read();
    q = 32'hFFFF_FFFF; cur_intt = 1;
    for (int k = 0; k < N; k++) stim[k] = k;
    load_full();
    ra = 3;
    step();
    checks++;
    if (din0 !== 32'd3 || din1 !== 32'd11) begin
      errors++;
      $display("FAIL rd_ra3: got %h/%h want 3/b", din0, din1);
    end
    repeat (8) rd_check($urandom_range(0, 7));
  endtask

  task automatic test_run_hold();
    int bad;
    bad = 0;
    finish = 0;
    repeat (100) begin
      step();
      if (ntt_start !== 1 || bus.m_valid !== 0 ||
          bus.s_ready !== 0 || ntt_intt !== cur_intt) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL run_hold: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_core_write();
    int a;
    ra = 2; wa = 2; wea = 1;
    dout0 = 32'hAA; dout1 = 32'hBB;
    step();
    checks++;
    if (din0 !== mdl[2] || din1 !== mdl[10]) begin
      errors++;
      $display("FAIL rbw_old: got %h/%h want %h/%h",
               din0, din1, mdl[2], mdl[10]);
    end
    mdl[2] = 32'hAA; mdl[10] = 32'hBB;
    wea = 0;
    step();
    checks++;
    if (din0 !== 32'hAA || din1 !== 32'hBB) begin
      errors++;
      $display("FAIL wr_new: got %h/%h want aa/bb", din0, din1);
    end
    repeat (5) begin
      a = (2 + $urandom_range(1, 7)) % 8;
      wa = AW'(a); wea = 1;
      dout0 = $urandom; dout1 = $urandom;
      mdl[a] = dout0; mdl[a+8] = dout1;
      step();
      wea = 0;
      rd_check(a);
    end
  endtask

  task automatic test_random_txn(input int mode);
    int a;
    cur_intt = 1'($urandom);
    q = $urandom_range(1, 32'h8000_0000);
    for (int k = 0; k < N; k++) stim[k] = $urandom;
    load_full();
    repeat ($urandom_range(2, 6)) begin
      a = $urandom_range(0, 7);
      wa = AW'(a); wea = 1;
      dout0 = $urandom; dout1 = $urandom;
      mdl[a] = dout0; mdl[a+8] = dout1;
      step();
      wea = 0;
    end
    rd_check($urandom_range(0, 7));
    finish_core();
    unload(mode);
  endtask

  task automatic test_reset_mid_load();
    cur_intt = 0;
    for (int k = 0; k < N; k++) stim[k] = $urandom;
    load_beats(0, 7);
    checks++;
    if (busy !== 1 || bus.s_ready !== 1) begin
      errors++;
      $display("FAIL partial_busy: busy %b rdy %b want 1/1",
               busy, bus.s_ready);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (bus.s_ready !== 1 || busy !== 0 || ntt_start !== 0) begin
      errors++;
      $display("FAIL abort_load: rdy %b busy %b st %b want 1/0/0",
               bus.s_ready, busy, ntt_start);
    end
    cur_intt = 1;
    for (int k = 0; k < N; k++) stim[k] = $urandom;
    load_beats(0, N - 1);
    checks++;
    if (bus.s_ready !== 1 || busy !== 1) begin
      errors++;
      $display("FAIL beat15_load: rdy %b busy %b want 1/1",
               bus.s_ready, busy);
    end
    load_beats(N - 1, 1);
    check_run_entry();
    finish_core();
    unload(1);
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < N; k++) stim[k] = $urandom;
    load_full();
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (ntt_start !== 0 || bus.s_ready !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL abort_run: st %b rdy %b busy %b want 0/1/0",
               ntt_start, bus.s_ready, busy);
    end
    rd_check($urandom_range(0, 7));
    for (int k = 0; k < N; k++) stim[k] = $urandom;
    load_full();
    finish_core();
    bus.m_ready = 0;
    repeat (3) step();
    checks++;
    if (bus.m_valid !== 1 || bus.m_data !== mdl[0]) begin
      errors++;
      $display("FAIL unload_stall: mv %b d %h want 1/%h",
               bus.m_valid, bus.m_data, mdl[0]);
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (bus.m_valid !== 0 || bus.s_ready !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL abort_unload: mv %b rdy %b busy %b want 0/1/0",
               bus.m_valid, bus.s_ready, busy);
    end
  endtask

  task automatic test_reduce();
    q = 17; cur_intt = 0;
    for (int k = 0; k < N; k++) stim[k] = $urandom_range(0, 33);
    stim[0] = 20; stim[3] = 17; stim[4] = 16;
    load_full();
    ra = 0;
    step();
    checks++;
    if (din0 !== EXP20) begin
      errors++;
      $display("FAIL reduce20: got %0d want %0d", din0, EXP20);
    end
    finish_core();
    unload(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_read();
    test_run_hold();
    test_core_write();
    finish_core();
    unload(0);
    test_random_txn(1);
    test_random_txn(2);
    test_random_txn(2);
    test_reset_mid_load();
    test_reset_mid_run();
    test_reduce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_coef_buffer.md
NTT_COEF_BUFFER -- requirements
Module: ntt_coef_buffer

Interface
REQ-001 Parameter LOGQ, default 60, coefficient width in bits.
REQ-002 Parameter LOGN, default 12, log2 of polynomial length N; legal range 4..16.
REQ-003 Address width AW SHALL be 10 when LOGN<9, else LOGN; only bits [LOGN-2:0] select a bank word.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_intt  input  1  transform direction, sampled with the first accepted load beat.
REQ-007 q  input  LOGQ  modulus, stable for the whole transaction.
REQ-008 s_valid / s_ready / s_data  in/out/in  1/1/LOGQ  load stream, natural coefficient order.
REQ-009 m_valid / m_ready / m_data / m_last  out/in/out/out  1/1/LOGQ/1  unload stream, natural order.
REQ-010 ntt_start / ntt_intt  out/out  1/1  NTT core start level and mode.
REQ-011 ntt_read_address / ntt_write_address / ntt_wea  in/in/in  AW/AW/1  core memory port.
REQ-012 ntt_data_in_0 / ntt_data_in_1  out  LOGQ  read data, low and high half.
REQ-013 ntt_data_out_0 / ntt_data_out_1 / ntt_finish  in/in/in  LOGQ/LOGQ/1  core write data and completion.
REQ-014 busy  out  1  high whenever state is not LOAD or a load is partially accepted.

Function
REQ-015 Storage SHALL be two banks of N/2 words each: bank0 holds index i<N/2, bank1 holds index i-N/2.
REQ-016 FSM states SHALL be LOAD, RUN, UNLOAD; rst enters LOAD.
REQ-017 LOAD: s_ready=1; each s_valid beat writes the word at load counter lc and increments lc; after beat N-1, lc wraps to 0 and the FSM enters RUN.
REQ-018 RUN: ntt_start SHALL rise the cycle after entry and stay high until the first cycle ntt_finish=1 is sampled; the FSM then enters UNLOAD with ntt_start=0 on the next cycle.
REQ-019 ntt_intt SHALL equal the cfg_intt value captured in REQ-006 for the whole RUN.
REQ-020 Read latency SHALL be exactly 1 cycle: ntt_data_in_0<=bank0[ra], ntt_data_in_1<=bank1[ra] every cycle in every state.
REQ-021 ntt_wea=1 SHALL write bank0[wa]<=ntt_data_out_0 and bank1[wa]<=ntt_data_out_1 at that edge; writes are accepted only in RUN.
REQ-022 Simultaneous read and write of the same address SHALL return the old data (read-before-write).
REQ-023 UNLOAD: words are emitted for index 0..N-1 through a registered output with one prefetch stage; m_valid holds, with m_data stable, until m_ready=1.
REQ-024 The first m_valid SHALL occur no later than 2 cycles after UNLOAD entry; with m_ready held at 1, throughput SHALL be 1 word per cycle.
REQ-025 m_last SHALL be high only with index N-1; its handshake returns the FSM to LOAD and drops busy.
REQ-026 s_ready SHALL be 0 outside LOAD; m_valid SHALL be 0 outside UNLOAD.
REQ-027 ntt_finish outside RUN SHALL be ignored.

Reset
REQ-028 rst SHALL clear the state to LOAD and set lc, the unload counter, ntt_start, m_valid, m_last and busy to 0, and set s_ready to 1 on the following cycle.
REQ-029 rst mid-LOAD, mid-RUN or mid-UNLOAD SHALL abort the transaction; bank contents are not cleared.
REQ-030 ntt_data_in_0 and ntt_data_in_1 SHALL reset to 0.

Configuration
REQ-031 Macro NTT_BUF_REDUCE_EN defined: a load beat with s_data>=q SHALL be stored as s_data-q (single conditional subtraction), adding no load latency.
REQ-032 Macro NTT_BUF_REDUCE_EN undefined: s_data SHALL be stored verbatim, with no comparator.

Verification
REQ-033 LOGN=4: load 0..15, model core reads ra=3 -> next cycle data_in_0=3 and data_in_1=11.
REQ-034 Load N words, core holds finish low 100 cycles -> ntt_start high through finish, then low; FSM enters UNLOAD.
REQ-035 Core writes wa=2 with 0xAA/0xBB; unload -> m_data index 2=0xAA, index 10=0xBB, m_last only on index 15.
REQ-036 m_ready toggled 1,0,0,1 during unload -> no word lost or duplicated; m_data stable while stalled.
REQ-037 Assert rst at load beat 7, then load 16 fresh words -> RUN entered only after the 16th post-reset beat.
REQ-038 NTT_BUF_REDUCE_EN defined, q=17, load 20 -> stored and unloaded as 3; undefined -> 20.
